lsu_byte_sequencer: RTL and testbench

//  Load/store sequencer between RV32I MEM stage and 8-bit x 2048 sync-read data BRAM.

---
 rtl/rv32_mem_pkg.sv | 28 ++
 rtl/lsu_load_extend.sv | 23 ++
 rtl/lsu_byte_sequencer.sv | 172 +++++++++++++++++
 tb/tb_lsu_byte_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the RV32I load/store path: funct3 codes, sequencer states,
// and the access-size decode used by the byte sequencer.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD,
        S_LDRAIN,
        S_RESP
    } state_t;

    // Bytes touched by an access, from funct3[1:0].
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero-extends reassembled load lanes according to funct3.
// Latency: combinational. Backpressure: none.
module lsu_load_extend
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] lanes,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = 32'h0;
        case (funct3)
            F3_B:    rdata = {{24{lanes[7]}}, lanes[7:0]};
            F3_H:    rdata = {{16{lanes[15]}}, lanes[15:0]};
            F3_W:    rdata = lanes;
            F3_BU:   rdata = {24'h0, lanes[7:0]};
            F3_HU:   rdata = {16'h0, lanes[15:0]};
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Splits RV32I loads/stores into byte accesses on an 8-bit sync-read BRAM.
// Latency: store N+1, load N+2, error 1 cycle after accept. Backpressure: req_ready low while busy.
module lsu_byte_sequencer #(
    parameter int ADDR_W = 11,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout
);
    import rv32_mem_pkg::*;

    state_t              state_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W-1:0]   base_q;
    logic [XLEN-1:0]     wdata_q;
    logic [2:0]          n_q;
    logic [2:0]          cyc_q;
    logic [31:0]         asm_q;
    logic [31:0]         asm_next;
    logic [31:0]         ext_rdata;
    logic [1:0]          lane;
    logic                acc_err;

    // Any of these means the request never touches the BRAM.
    always_comb begin
        acc_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
               || (req_we && req_funct3[2])
               || (req_funct3[1:0] == 2'b01 && req_addr[0])
               || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
               || (req_addr[XLEN-1:ADDR_W] != '0);
    end

    // Read data for byte i arrives two cycles after its issue cycle; cyc_q-2 is the lane landing now.
    always_comb begin
        lane     = 2'(cyc_q - 3'd2);
        asm_next = asm_q;
        if ((state_q == S_LOAD || state_q == S_LDRAIN) && cyc_q >= 3'd2)
            asm_next[{lane, 3'b000} +: 8] = mem_dout;
    end

    lsu_load_extend u_ext (
        .funct3 (funct3_q),
        .lanes  (asm_next),
        .rdata  (ext_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            funct3_q   <= 3'h0;
            base_q     <= '0;
            wdata_q    <= '0;
            n_q        <= 3'h0;
            cyc_q      <= 3'h0;
            asm_q      <= 32'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= 8'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    mem_en     <= 1'b0;
                    mem_we     <= 1'b0;
                    mem_addr   <= '0;
                    mem_din    <= 8'h0;
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        base_q    <= req_addr[ADDR_W-1:0];
                        wdata_q   <= req_wdata;
                        n_q       <= size_bytes(req_funct3[1:0]);
                        cyc_q     <= 3'd1;
                        asm_q     <= 32'h0;
                        req_ready <= 1'b0;
                        if (acc_err) begin
                            state_q    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we) begin
                            state_q  <= S_STORE;
                            mem_en   <= 1'b1;
                            mem_we   <= 1'b1;
                            mem_addr <= req_addr[ADDR_W-1:0];
                            mem_din  <= req_wdata[7:0];
                        end else begin
                            state_q  <= S_LOAD;
                            mem_en   <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= req_addr[ADDR_W-1:0];
                        end
                    end
                end

                S_STORE: begin
                    cyc_q <= cyc_q + 3'd1;
                    if (cyc_q < n_q) begin
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= base_q + ADDR_W'(cyc_q);
                        mem_din  <= wdata_q[{cyc_q[1:0], 3'b000} +: 8];
                    end else begin
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= '0;
                        mem_din    <= 8'h0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        state_q    <= S_RESP;
                    end
                end

                S_LOAD: begin
                    cyc_q <= cyc_q + 3'd1;
                    asm_q <= asm_next;
                    if (cyc_q < n_q) begin
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= base_q + ADDR_W'(cyc_q);
                    end else begin
                        mem_en   <= 1'b0;
                        mem_addr <= '0;
                        state_q  <= S_LDRAIN;
                    end
                end

                S_LDRAIN: begin
                    cyc_q      <= cyc_q + 3'd1;
                    asm_q      <= asm_next;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= ext_rdata;
                    state_q    <= S_RESP;
                end

                S_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    state_q    <= S_IDLE;
                end

                default: begin
                    state_q   <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Self-checking bench: directed vector table, reset/back-to-back sequences, random vs. byte-array model.
module tb_lsu_byte_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = 8'h00;

    logic [7:0]  bram    [0:2047] = '{default: 8'h00};
    logic [7:0]  ref_mem [0:2047] = '{default: 8'h00};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_byte_sequencer #(.ADDR_W(11), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_din;
            else        mem_dout <= bram[mem_addr];
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: the access as N consecutive bytes of a flat little-endian array.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output logic er, output int lat);
        int n;
        n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        er = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2])
          || (addr >= 32'd2048) || ((addr % n) != 0);
        rd = 32'h0;
        if (er) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            lat = n + 1;
        end else begin
            for (int i = 0; i < n; i++) rd = rd | (32'(ref_mem[addr + i]) << (8*i));
            if (!f3[2] && n < 4 && rd[8*n-1]) rd = rd | ~((32'h1 << (8*n)) - 32'h1);
            lat = n + 2;
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd,
                          output logic er, output int lat, output logic saw_en);
        int w;
        rd = 32'h0; er = 1'b0; lat = 0; saw_en = 1'b0;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid  = 1'b0;
                req_we     = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
            if (mem_en) saw_en = 1'b1;
            if (resp_valid) begin
                rd = resp_rdata; er = resp_err; lat = c;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            chk("resp_pulse_then_ready", {30'h0, resp_valid, req_ready}, 32'h1);
        end
    endtask

    task automatic check_one(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        saw_en;
        do_req(we, f3, addr, wdata, rd, er, lat, saw_en);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, {31'h0, er}, {31'h0, exp_er});
        chk({tag, "_lat"}, lat, exp_lat);
        if (exp_er) chk({tag, "_no_mem_en"}, {31'h0, saw_en}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [14];
        logic [31:0] e_rd;
        logic        e_er;
        int          e_lat;
        int          acc_t [4];
        int          k;
        int          pulses;
        logic [2:0]  legal [5];
        logic [2:0]  bad   [3];
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        we;

        tbl[0]  = '{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 5};
        tbl[1]  = '{1'b0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 6};
        tbl[2]  = '{1'b1, 3'b000, 32'h7FF, 32'h00000080, 32'h00000000, 1'b0, 2};
        tbl[3]  = '{1'b0, 3'b000, 32'h7FF, 32'h0,        32'hFFFFFF80, 1'b0, 3};
        tbl[4]  = '{1'b0, 3'b100, 32'h7FF, 32'h0,        32'h00000080, 1'b0, 3};
        tbl[5]  = '{1'b1, 3'b001, 32'h002, 32'h12348001, 32'h00000000, 1'b0, 3};
        tbl[6]  = '{1'b0, 3'b001, 32'h002, 32'h0,        32'hFFFF8001, 1'b0, 4};
        tbl[7]  = '{1'b0, 3'b101, 32'h002, 32'h0,        32'h00008001, 1'b0, 4};
        tbl[8]  = '{1'b0, 3'b100, 32'h004, 32'h0,        32'h00000000, 1'b0, 3};
        tbl[9]  = '{1'b0, 3'b010, 32'h003, 32'h0,        32'h00000000, 1'b1, 1};
        tbl[10] = '{1'b0, 3'b001, 32'h005, 32'h0,        32'h00000000, 1'b1, 1};
        tbl[11] = '{1'b1, 3'b010, 32'h800, 32'h11223344, 32'h00000000, 1'b1, 1};
        tbl[12] = '{1'b0, 3'b011, 32'h010, 32'h0,        32'h00000000, 1'b1, 1};
        tbl[13] = '{1'b1, 3'b100, 32'h010, 32'h000000AA, 32'h00000000, 1'b1, 1};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0;
        req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge clk); @(negedge clk);
        chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata,          32'h0);
        chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
        chk("rst_mem_ctl",    {29'h0, mem_en, mem_we, |mem_din}, 32'h0);
        chk("rst_mem_addr",   {21'h0, mem_addr},   32'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            check_one($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr,
                      tbl[i].wdata, tbl[i].rdata, tbl[i].err, tbl[i].lat);

        chk("bram_10", {24'h0, bram[11'h010]}, 32'hEF);
        chk("bram_11", {24'h0, bram[11'h011]}, 32'hBE);
        chk("bram_12", {24'h0, bram[11'h012]}, 32'hAD);
        chk("bram_13", {24'h0, bram[11'h013]}, 32'hDE);
        chk("bram_04_untouched", {24'h0, bram[11'h004]}, 32'h00);

        // Reset during the third cycle of a word load.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midop_mem_en_before_rst", {31'h0, mem_en}, 32'h1);
        rst = 1'b1;
        #1;
        chk("midop_rst_mem_en",    {31'h0, mem_en},     32'h0);
        chk("midop_rst_req_ready", {31'h0, req_ready},  32'h1);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        chk("midop_no_resp", pulses, 0);
        check_one("after_rst_lw", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 6);

        // Four byte stores with req_valid held high throughout.
        k = 0; pulses = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
            if (req_ready) begin
                if (k < 4) begin
                    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
                    req_addr = 32'h20 + 32'(k); req_wdata = 32'h11 * 32'(k + 1);
                    acc_t[k] = t;
                    k++;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", k, 4);
        for (int i = 1; i < 4; i++) chk($sformatf("b2b_gap%0d", i), acc_t[i] - acc_t[i-1], 3);
        chk("b2b_pulses", pulses, 4);
        check_one("b2b_rd0", 1'b0, 3'b100, 32'h20, 32'h0, 32'h11, 1'b0, 3);
        check_one("b2b_rd3", 1'b0, 3'b100, 32'h23, 32'h0, 32'h44, 1'b0, 3);

        // Random traffic against the model; model state starts from what the directed part wrote.
        for (int a = 0; a < 2048; a++) ref_mem[a] = bram[a];
        legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bad   = '{3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 60; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = ($urandom_range(0, 9) == 0) ? bad[$urandom_range(0, 2)]
                                               : legal[$urandom_range(0, 4)];
            if (we && $urandom_range(0, 3) != 0) f3 = {1'b0, f3[1:0]};
            addr = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0)
                addr = ($urandom_range(0, 1) == 0) ? (32'h800 + 32'($urandom_range(0, 255)))
                                                   : (addr | 32'h0001_0000);
            req_wdata = $urandom;
            model(we, f3, addr, req_wdata, e_rd, e_er, e_lat);
            check_one($sformatf("rnd%0d", i), we, f3, addr, req_wdata, e_rd, e_er, e_lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
